// File: rtl/axis_packetizer.sv
// axis_packetizer: frames an AXI-Stream byte stream into header/length/payload/checksum packets
module axis_packetizer #(
  parameter int PAYLOAD_LEN = 8,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       pkt_done
);
  typedef enum logic [1:0] {HDR, LEN, PAY, CSUM} state_t;
  localparam logic [7:0] LEN_B = 8'(PAYLOAD_LEN);
  state_t state, state_nxt;
  logic [7:0] cnt, csum, load_data;
  logic slot_free, accept, load, load_last;
  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = aresetn && state == PAY && slot_free;
  assign accept = s_axis_tvalid && s_axis_tready;
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    load_data = HDR_BYTE;
    load_last = 1'b0;
    case (state)
      HDR: if (s_axis_tvalid && slot_free) begin
        load = 1'b1;
        state_nxt = LEN;
      end
      LEN: if (slot_free) begin
        load = 1'b1;
        load_data = LEN_B;
        state_nxt = PAY;
      end
      PAY: if (accept) begin
        load = 1'b1;
        load_data = s_axis_tdata;
        state_nxt = cnt == LEN_B - 8'd1 ? CSUM : PAY;
      end
      CSUM: if (slot_free) begin
        load = 1'b1;
        load_data = csum;
        load_last = 1'b1;
        state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= HDR;
      cnt <= 8'h00;
      csum <= 8'h00;
      m_axis_tdata <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      state <= state_nxt;
      pkt_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
      if (load) begin
        m_axis_tdata <= load_data;
        m_axis_tlast <= load_last;
        m_axis_tvalid <= 1'b1;
      end else if (slot_free) begin
        m_axis_tvalid <= 1'b0;
      end
      // the checksum register already holds the last payload byte by the time CSUM loads it
      if (state == LEN && slot_free) begin
        cnt <= 8'h00;
        csum <= 8'h00;
      end else if (accept) begin
        cnt <= cnt + 8'd1;
        csum <= csum + s_axis_tdata;
      end
    end
  end
endmodule
